// File: rtl/serial_sub_8.sv
// Bit-serial 8-bit subtractor: a - b computed STEP bits per cycle with a
// valid/ready handshake on both sides. Reports unsigned borrow and signed overflow.
module serial_sub_8 #(
  parameter int unsigned STEP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] diff,
  output logic       borrow,
  output logic       ovf
);

  localparam int unsigned W      = 8;
  localparam int unsigned IW     = $clog2(W);
  localparam int unsigned SAFE_S = (STEP == 0) ? 1 : STEP;
  localparam int unsigned NCHUNK = W / SAFE_S;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  // Only chunk widths that tile the word exactly are meaningful.
  generate
    if (STEP == 0 || STEP > W || (W % SAFE_S) != 0) begin : g_bad_step
      $error("serial_sub_8: STEP must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [IW-1:0]    base;
  logic [STEP-1:0]  a_chunk;
  logic [STEP-1:0]  b_chunk;
  logic [STEP:0]    sum;
  logic [W-1:0]     diff_nx;
  logic             last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One chunk of the ripple: a + ~b + carry, spliced into the running diff.
  always_comb begin
    base     = IW'(32'(cnt) * STEP);
    a_chunk  = a_q[base +: STEP];
    b_chunk  = b_q[base +: STEP];
    sum      = {1'b0, a_chunk} + {1'b0, ~b_chunk} + (STEP+1)'(carry);
    diff_nx  = diff;
    diff_nx[base +: STEP] = sum[STEP-1:0];
    last     = (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = BUSY;
      BUSY:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Operand capture, per-chunk update and final flag computation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      carry  <= 1'b1;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            cnt   <= '0;
            carry <= 1'b1;
          end
        end
        BUSY: begin
          diff  <= diff_nx;
          carry <= sum[STEP];
          cnt   <= cnt + CW'(1);
          if (last) begin
            borrow <= ~sum[STEP];
            ovf    <= (a_q[W-1] != b_q[W-1]) && (diff_nx[W-1] != a_q[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_8.sv
// Self-checking bench: four serial_sub_8 instances (STEP 1/2/4/8) share inputs
// and are compared against plain-arithmetic subtraction results.
module tb_serial_sub_8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_ready;
  logic [3:0] in_ready;
  logic [3:0] out_valid;
  logic [7:0] diff [4];
  logic [3:0] borrow;
  logic [3:0] ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance g uses STEP = 1 << g.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_sub_8 #(.STEP(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .a         (a),
      .b         (b),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .diff      (diff[g]),
      .borrow    (borrow[g]),
      .ovf       (ovf[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int step_of(input int i);
    return 1 << i;
  endfunction

  // Reference arithmetic from the operand values alone.
  task automatic ref_sub(input logic [7:0] ra, input logic [7:0] rb,
                         output logic [7:0] ed, output logic eb, output logic eo);
    int r;
    ed = ra - rb;
    eb = (ra < rb);
    r  = int'($signed(ra)) - int'($signed(rb));
    eo = (r > 127) || (r < -128);
  endtask

  // One full transaction with out_ready held high; accept edge counts as edge 1.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb);
    logic [7:0] ed;
    logic       eb;
    logic       eo;
    bit         seen [4];
    ref_sub(ta, tb, ed, eb, eo);
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    check("pre_in_ready", 32'(in_ready), 32'hF);
    a = ta; b = tb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post_accept_in_ready", 32'(in_ready), 32'h0);
    for (int e = 2; e <= 13; e++) begin
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && !seen[i]) begin
          seen[i] = 1'b1;
          check($sformatf("latency_s%0d", step_of(i)), 32'(e), 32'((8 / step_of(i)) + 1));
          check($sformatf("diff_s%0d", step_of(i)), 32'(diff[i]), 32'(ed));
          check($sformatf("borrow_s%0d", step_of(i)), 32'(borrow[i]), 32'(eb));
          check($sformatf("ovf_s%0d", step_of(i)), 32'(ovf[i]), 32'(eo));
        end
      end
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("result_seen_s%0d", step_of(i)), 32'(seen[i]), 32'd1);
    check("end_in_ready", 32'(in_ready), 32'hF);
    check("end_out_valid", 32'(out_valid), 32'h0);
  endtask

  // Result held under backpressure while inputs wiggle; release returns to IDLE.
  task automatic run_backpressure(input logic [7:0] ta, input logic [7:0] tb);
    logic [7:0] ed;
    logic       eb;
    logic       eo;
    ref_sub(ta, tb, ed, eb, eo);
    a = ta; b = tb; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    for (int e = 2; e <= 16; e++) begin
      a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i]) begin
          check($sformatf("bp_diff_s%0d", step_of(i)), 32'(diff[i]), 32'(ed));
          check($sformatf("bp_borrow_s%0d", step_of(i)), 32'(borrow[i]), 32'(eb));
          check($sformatf("bp_ovf_s%0d", step_of(i)), 32'(ovf[i]), 32'(eo));
        end
      end
      check("bp_in_ready", 32'(in_ready), 32'h0);
    end
    check("bp_all_done", 32'(out_valid), 32'hF);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'hF);
    check("bp_release_out_valid", 32'(out_valid), 32'h0);
  endtask

  initial begin
    logic [7:0] corner [4];
    corner[0] = 8'h00; corner[1] = 8'hFF; corner[2] = 8'h7F; corner[3] = 8'h80;
    rst_n = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'hF);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) check($sformatf("rst_diff_s%0d", step_of(i)), 32'(diff[i]), 32'h0);
    check("rst_borrow", 32'(borrow), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h05, 8'h03);
    run_op(8'h03, 8'h05);
    run_op(8'h00, 8'h00);
    run_op(8'h80, 8'h01);
    run_op(8'h7F, 8'hFF);

    run_backpressure(8'h80, 8'h01);

    // Abort mid-operation: reset takes effect between edges, no result follows.
    run_op(8'h03, 8'h05);
    a = 8'h44; b = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'hF);
    check("abort_out_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) check($sformatf("abort_diff_s%0d", step_of(i)), 32'(diff[i]), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      check("abort_no_result", 32'(out_valid), 32'h0);
    end
    run_op(8'h44, 8'h11);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        run_op(corner[i], corner[j]);
    for (int n = 0; n < 256; n++)
      run_op(8'($urandom), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
